// File: rtl/dsp_dpram_rd_pkg.sv
// Shared types and defaults for the DSP-to-FPGA DPRAM reader.
package dsp_dpram_rd_pkg;

  typedef enum logic [1:0] {REG_HDR, REG_PHA, REG_PHB, REG_PHC} region_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_DRAIN, ST_COMMIT} state_e;

  localparam logic [9:0] DEF_BASE_ADDR = 10'h200;
  localparam int DEF_NUM_HDR = 8;
  localparam int DEF_NUM_PH  = 32;
  localparam int DEF_OVR_W   = 8;

  // In-region word index; the TX address only carries 5 index bits.
  localparam int IDX_W = 5;

  localparam int HDR_CTRL  = 0;
  localparam int HDR_RENEW = 1;
  localparam int HDR_MODE  = 2;

endpackage

// File: rtl/dsp_dpram_rd_sum_chk.sv
// Running 16-bit region checksum; last word of a region must equal ~sum.
module dsp_dpram_rd_sum_chk (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        first_i,
  input  logic        last_i,
  input  logic [15:0] data_i,
  output logic        err_o
);

  logic [15:0] sum_q, acc;

  assign acc   = first_i ? 16'h0000 : sum_q;
  assign err_o = en_i & last_i & (data_i != ~acc);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)              sum_q <= '0;
    else if (en_i && !last_i)  sum_q <= acc + data_i;
  end

endmodule

// File: rtl/dsp_dpram_rd.sv
// Streams the DSP block out of DPRAM, checks per-region sums, latches the
// header and fills the inactive per-phase TX bank, swapping only good phases.
module dsp_dpram_rd
  import dsp_dpram_rd_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int         NUM_HDR   = DEF_NUM_HDR,
  parameter int         NUM_PH    = DEF_NUM_PH,
  parameter int         OVR_W     = DEF_OVR_W
) (
  input  logic             clk_100M,
  input  logic             reset_n,
  input  logic             XWR_DONE,
  output logic [9:0]       o_dp_addr,
  input  logic [15:0]      i_dp_data,
  output logic [2:0]       o_tx_wea,
  output logic [9:0]       o_tx_addr,
  output logic [15:0]      o_tx_data,
  output logic [2:0]       tx_bank,
  output logic [15:0]      ctrl_word,
  output logic [15:0]      renewal_cnt,
  output logic [15:0]      mode_word,
  output logic             cmd_done,
  output logic             cmd_stale,
  output logic [3:0]       sum_err,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic [OVR_W-1:0] err_cnt,
  output logic             rd_busy
);

  localparam int N  = NUM_HDR + 3 * NUM_PH;
  localparam int KW = $clog2(N);
  localparam logic [IDX_W-1:0] HDR_LAST = IDX_W'(NUM_HDR - 1);
  localparam logic [IDX_W-1:0] PH_LAST  = IDX_W'(NUM_PH - 1);

  logic [2:0]       sync_q;
  logic             edge_w, start;
  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  region_e          areg_q, areg_d, creg_q;
  logic [IDX_W-1:0] aidx_q, aidx_d, cidx_q, tidx;
  logic [1:0]       vld_pipe_q;
  logic             cap_last, ph_data, chk_err, bank_sel;
  logic [3:0]       err_stg_q, bank_ext, wr_oh;
  logic [15:0]      stg_ctrl_q, stg_ren_q, stg_mode_q;

  logic [9:0]       dp_addr_q, tx_addr_q;
  logic [2:0]       tx_wea_q, tx_bank_q;
  logic [15:0]      tx_data_q, ctrl_q, ren_q, mode_q;
  logic             done_q, stale_q, busy_q;
  logic [3:0]       sum_err_q;
  logic [OVR_W-1:0] ovr_q, err_q;

  assign edge_w = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    areg_d  = areg_q;
    aidx_d  = aidx_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: if (edge_w) begin
        state_d = ST_RD;
        k_d     = '0;
        areg_d  = REG_HDR;
        aidx_d  = '0;
        start   = 1'b1;
      end
      ST_RD: begin
        if (k_q == KW'(N - 1)) state_d = ST_DRAIN;
        else begin
          k_d = k_q + KW'(1);
          if (aidx_q == ((areg_q == REG_HDR) ? HDR_LAST : PH_LAST)) begin
            aidx_d = '0;
            areg_d = region_e'(areg_q + 2'd1);
          end else begin
            aidx_d = aidx_q + IDX_W'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_COMMIT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Capture stage: vld_pipe_q[1] marks i_dp_data belonging to creg_q/cidx_q.
  assign cap_last = cidx_q == ((creg_q == REG_HDR) ? HDR_LAST : PH_LAST);
  assign ph_data  = vld_pipe_q[1] && (creg_q != REG_HDR) && !cap_last;
  assign bank_ext = {tx_bank_q, 1'b0};
  assign bank_sel = bank_ext[creg_q];
  assign wr_oh    = 4'b0001 << creg_q;
  assign tidx     = cidx_q + IDX_W'(1);

  dsp_dpram_rd_sum_chk u_chk (
    .clk_i   (clk_100M),
    .rst_n_i (reset_n),
    .en_i    (vld_pipe_q[1]),
    .first_i (cidx_q == '0),
    .last_i  (cap_last),
    .data_i  (i_dp_data),
    .err_o   (chk_err)
  );

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      state_q    <= ST_IDLE;
      k_q        <= '0;
      areg_q     <= REG_HDR;
      aidx_q     <= '0;
      creg_q     <= REG_HDR;
      cidx_q     <= '0;
      vld_pipe_q <= '0;
      err_stg_q  <= '0;
      stg_ctrl_q <= '0;
      stg_ren_q  <= '0;
      stg_mode_q <= '0;
      dp_addr_q  <= '0;
      tx_wea_q   <= '0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_bank_q  <= '0;
      ctrl_q     <= '0;
      ren_q      <= '0;
      mode_q     <= '0;
      done_q     <= 1'b0;
      stale_q    <= 1'b0;
      busy_q     <= 1'b0;
      sum_err_q  <= '0;
      ovr_q      <= '0;
      err_q      <= '0;
    end else begin
      sync_q     <= {sync_q[1:0], XWR_DONE};
      state_q    <= state_d;
      k_q        <= k_d;
      areg_q     <= areg_d;
      aidx_q     <= aidx_d;
      creg_q     <= areg_q;
      cidx_q     <= aidx_q;
      vld_pipe_q <= {vld_pipe_q[0], state_d == ST_RD};
      done_q     <= state_d == ST_COMMIT;
      busy_q     <= state_d != ST_IDLE;
      if (state_d == ST_RD) dp_addr_q <= BASE_ADDR + 10'(k_d);

      if (edge_w && state_q != ST_IDLE && ovr_q != '1) ovr_q <= ovr_q + OVR_W'(1);

      if (start)        err_stg_q <= '0;
      else if (chk_err) err_stg_q <= err_stg_q | wr_oh;

      if (vld_pipe_q[1] && creg_q == REG_HDR) begin
        if (cidx_q == IDX_W'(HDR_CTRL))  stg_ctrl_q <= i_dp_data;
        if (cidx_q == IDX_W'(HDR_RENEW)) stg_ren_q  <= i_dp_data;
        if (cidx_q == IDX_W'(HDR_MODE))  stg_mode_q <= i_dp_data;
      end

      // Phase data always lands in the inactive bank; idx 0 stays reserved.
      tx_wea_q <= ph_data ? wr_oh[3:1] : 3'b000;
      if (ph_data) begin
        tx_addr_q <= {~bank_sel, 4'b0000, tidx};
        tx_data_q <= i_dp_data;
      end

      if (state_q == ST_COMMIT) begin
        sum_err_q <= err_stg_q;
        tx_bank_q <= tx_bank_q ^ ~err_stg_q[3:1];
        if (!err_stg_q[0]) begin
          ctrl_q  <= stg_ctrl_q;
          ren_q   <= stg_ren_q;
          mode_q  <= stg_mode_q;
          stale_q <= stg_ren_q == ren_q;
        end
        if (err_stg_q != '0 && err_q != '1) err_q <= err_q + OVR_W'(1);
      end
    end
  end

  assign o_dp_addr   = dp_addr_q;
  assign o_tx_wea    = tx_wea_q;
  assign o_tx_addr   = tx_addr_q;
  assign o_tx_data   = tx_data_q;
  assign tx_bank     = tx_bank_q;
  assign ctrl_word   = ctrl_q;
  assign renewal_cnt = ren_q;
  assign mode_word   = mode_q;
  assign cmd_done    = done_q;
  assign cmd_stale   = stale_q;
  assign sum_err     = sum_err_q;
  assign ovr_cnt     = ovr_q;
  assign err_cnt     = err_q;
  assign rd_busy     = busy_q;

endmodule

// File: tb/tb_dsp_dpram_rd.sv
// Bench for dsp_dpram_rd: DPRAM/TX RAM models, table-driven passes with a
// scoreboard queue, plus overrun, saturation and mid-pass reset sequences.
module tb_dsp_dpram_rd;

  localparam logic [9:0] BASE = 10'h200;
  localparam int NH  = 8;
  localparam int NP  = 32;
  localparam int N   = NH + 3 * NP;
  // Drive at a negedge; two sync flops put the edge cycle after the 2nd
  // posedge, cmd_done lands N+2 cycles later.
  localparam int LAT = N + 4;

  typedef struct {
    logic [15:0] ctrl, ren, mode;
    logic        stale;
    logic [3:0]  se;
    logic [2:0]  bank;
    logic [7:0]  err;
  } exp_t;

  typedef struct {
    logic [15:0] c, r, m;
    logic [3:0]  bad;
    exp_t        e;
  } vec_t;

  logic clk_100M = 1'b0;
  logic reset_n  = 1'b1;
  logic XWR_DONE = 1'b0;
  logic [9:0]  o_dp_addr, o_tx_addr;
  logic [15:0] i_dp_data = '0;
  logic [2:0]  o_tx_wea, tx_bank;
  logic [15:0] o_tx_data, ctrl_word, renewal_cnt, mode_word;
  logic        cmd_done, cmd_stale, rd_busy;
  logic [3:0]  sum_err;
  logic [7:0]  ovr_cnt, err_cnt;

  always #5 clk_100M = ~clk_100M;

  dsp_dpram_rd #(.BASE_ADDR(BASE), .NUM_HDR(NH), .NUM_PH(NP), .OVR_W(8)) dut (
    .clk_100M(clk_100M), .reset_n(reset_n), .XWR_DONE(XWR_DONE),
    .o_dp_addr(o_dp_addr), .i_dp_data(i_dp_data),
    .o_tx_wea(o_tx_wea), .o_tx_addr(o_tx_addr), .o_tx_data(o_tx_data),
    .tx_bank(tx_bank), .ctrl_word(ctrl_word), .renewal_cnt(renewal_cnt),
    .mode_word(mode_word), .cmd_done(cmd_done), .cmd_stale(cmd_stale),
    .sum_err(sum_err), .ovr_cnt(ovr_cnt), .err_cnt(err_cnt), .rd_busy(rd_busy)
  );

  logic [15:0] dpram [0:1023];
  logic [15:0] txram [0:2][0:1023];
  int done_cnt = 0, wr_cnt = 0, wr_viol = 0;

  always @(posedge clk_100M) i_dp_data <= dpram[o_dp_addr];

  // TX RAM model plus write-rule monitor: one phase at a time, inactive bank
  // only, never index 0, never outside a pass.
  always @(posedge clk_100M) begin
    if (cmd_done) done_cnt <= done_cnt + 1;
    for (int p = 0; p < 3; p++)
      if (o_tx_wea[p]) txram[p][o_tx_addr] <= o_tx_data;
    if (o_tx_wea != 3'b000) begin
      wr_cnt <= wr_cnt + 1;
      if ($countones(o_tx_wea) != 1 || !rd_busy || o_tx_addr[4:0] == 5'd0 ||
          |(o_tx_wea & ~(tx_bank ^ {3{o_tx_addr[9]}})))
        wr_viol <= wr_viol + 1;
    end
  end

  int total = 0, bad = 0;
  int cyc, done_at, pass_no = 0, exp_ovr = 0;
  exp_t sbq[$];
  exp_t cur;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    cyc++;
    @(negedge clk_100M);
    if (cmd_done && done_at == 0) done_at = cyc;
  endtask

  function automatic logic [15:0] phd(input int pass, input int p, input int j);
    return 16'(((p + 1) << 8) + j) ^ 16'(pass * 16'h1357);
  endfunction

  function automatic vec_t mk(input logic [15:0] c, r, m, input logic [3:0] b,
                              input logic [15:0] ec, er, em, input logic es,
                              input logic [3:0] ese, input logic [2:0] eb,
                              input logic [7:0] ee);
    vec_t v;
    v.c = c; v.r = r; v.m = m; v.bad = b;
    v.e.ctrl = ec; v.e.ren = er; v.e.mode = em; v.e.stale = es;
    v.e.se = ese; v.e.bank = eb; v.e.err = ee;
    return v;
  endfunction

  task automatic load_block(input vec_t v, input int pass);
    logic [15:0] s, w;
    s = '0;
    for (int i = 0; i < NH - 1; i++) begin
      w = (i == 0) ? v.c : (i == 1) ? v.r : (i == 2) ? v.m : (16'hA5A0 + 16'(i)) ^ 16'(pass);
      dpram[BASE + 10'(i)] = w;
      s += w;
    end
    dpram[BASE + 10'(NH - 1)] = ~s ^ {15'b0, v.bad[0]};
    for (int p = 0; p < 3; p++) begin
      s = '0;
      for (int j = 0; j < NP - 1; j++) begin
        w = phd(pass, p, j);
        dpram[BASE + 10'(NH + p * NP + j)] = w;
        s += w;
      end
      dpram[BASE + 10'(NH + p * NP + NP - 1)] = ~s ^ {15'b0, v.bad[p + 1]};
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hdr"}, {ctrl_word, renewal_cnt, mode_word}, 64'd0);
    chk({tag, "_tx"}, {o_dp_addr, o_tx_wea, o_tx_addr, o_tx_data}, 64'd0);
    chk({tag, "_stat"}, {tx_bank, cmd_done, cmd_stale, sum_err, ovr_cnt, err_cnt, rd_busy}, 64'd0);
  endtask

  task automatic run_pass(input vec_t v, input int n_ovr);
    exp_t e;
    int d0, w0, mism;
    logic [9:0] a;
    load_block(v, pass_no);
    sbq.push_back(v.e);
    d0 = done_cnt; w0 = wr_cnt;
    cyc = 0; done_at = 0;
    XWR_DONE = 1'b1;
    repeat (3) tick();
    XWR_DONE = 1'b0;
    while (!rd_busy && cyc < 20) tick();
    chk("start_busy", rd_busy, 1'b1);
    chk("start_addr", o_dp_addr, BASE);
    repeat ((n_ovr == 1) ? 17 : 2) tick();
    for (int i = 0; i < n_ovr; i++) begin
      XWR_DONE = 1'b1;
      repeat (3) tick();
      XWR_DONE = 1'b0;
      repeat (3) tick();
    end
    while (done_at == 0 && cyc < 400) tick();
    chk("latency", done_at, LAT);
    tick();
    chk("done_pulse", cmd_done, 1'b0);
    chk("busy_low", rd_busy, 1'b0);
    e = sbq.pop_front();
    chk("ctrl_word", ctrl_word, e.ctrl);
    chk("renewal_cnt", renewal_cnt, e.ren);
    chk("mode_word", mode_word, e.mode);
    chk("cmd_stale", cmd_stale, e.stale);
    chk("sum_err", sum_err, e.se);
    chk("tx_bank", tx_bank, e.bank);
    chk("err_cnt", err_cnt, e.err);
    exp_ovr = (exp_ovr + n_ovr > 255) ? 255 : exp_ovr + n_ovr;
    chk("ovr_cnt", ovr_cnt, exp_ovr);
    chk("done_count", done_cnt - d0, 1);
    chk("wr_count", wr_cnt - w0, 3 * (NP - 1));
    mism = 0;
    for (int p = 0; p < 3; p++)
      if (!v.bad[p + 1])
        for (int j = 0; j < NP - 1; j++) begin
          a = {e.bank[p], 4'b0000, 5'(j + 1)};
          if (txram[p][a] !== phd(pass_no, p, j)) mism++;
        end
    chk("txram", mism, 0);
    cur = e;
    pass_no++;
    repeat (3) tick();
  endtask

  initial begin
    int d0;
    logic [15:0] r;
    // Checking order runs from reset: renewal 0, banks 000, err_cnt 0.
    tbl[0] = mk(16'h1234, 16'd1, 16'h0005, 4'b0000, 16'h1234, 16'd1, 16'h0005, 1'b0, 4'b0000, 3'b111, 8'd0);
    tbl[1] = mk(16'hABCD, 16'd2, 16'h0007, 4'b0100, 16'hABCD, 16'd2, 16'h0007, 1'b0, 4'b0100, 3'b010, 8'd1);
    tbl[2] = mk(16'h5555, 16'd3, 16'h0009, 4'b0001, 16'hABCD, 16'd2, 16'h0007, 1'b0, 4'b0001, 3'b101, 8'd2);
    tbl[3] = mk(16'h1111, 16'd2, 16'h0001, 4'b0000, 16'h1111, 16'd2, 16'h0001, 1'b1, 4'b0000, 3'b010, 8'd2);
    tbl[4] = mk(16'h2222, 16'd2, 16'h0002, 4'b1000, 16'h2222, 16'd2, 16'h0002, 1'b1, 4'b1000, 3'b001, 8'd3);
    tbl[5] = mk(16'h3333, 16'd4, 16'h0003, 4'b0000, 16'h3333, 16'd4, 16'h0003, 1'b0, 4'b0000, 3'b110, 8'd3);
    tbl[6] = mk(16'h4444, 16'd5, 16'h0004, 4'b1111, 16'h3333, 16'd4, 16'h0003, 1'b0, 4'b1111, 3'b110, 8'd4);

    #1 reset_n = 1'b0;
    #2 chk_reset("reset");
    repeat (3) @(negedge clk_100M);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_100M);

    foreach (tbl[i]) run_pass(tbl[i], 0);

    // Second trigger ~20 cycles into a pass; renewal repeats -> stale.
    run_pass(mk(16'h8888, 16'd4, 16'h0008, 4'b0000, 16'h8888, 16'd4, 16'h0008, 1'b1, 4'b0000, 3'b001, 8'd4), 1);

    // 15 overruns per pass: 241 after 16 passes, saturated after 18.
    for (int i = 0; i < 18; i++) begin
      r = 16'(100 + i);
      run_pass(mk(16'h6000 + 16'(i), r, 16'(i), 4'b0000, 16'h6000 + 16'(i), r, 16'(i),
                  1'b0, 4'b0000, cur.bank ^ 3'b111, cur.err), 15);
    end

    // Reset mid-pass at k=50.
    load_block(tbl[0], pass_no);
    cyc = 0; done_at = 0;
    XWR_DONE = 1'b1;
    repeat (3) tick();
    XWR_DONE = 1'b0;
    while (o_dp_addr != BASE + 10'd50 && cyc < 200) tick();
    chk("k50_reached", o_dp_addr, BASE + 10'd50);
    reset_n = 1'b0;
    #1 chk_reset("midreset");
    exp_ovr = 0;
    d0 = done_cnt;
    repeat (3) @(negedge clk_100M);
    reset_n = 1'b1;
    repeat (120) tick();
    chk("no_done_after_reset", done_cnt - d0, 0);
    pass_no++;
    run_pass(mk(16'h7777, 16'd1, 16'h000A, 4'b0000, 16'h7777, 16'd1, 16'h000A, 1'b0, 4'b0000, 3'b111, 8'd0), 0);

    chk("wr_rules", wr_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
